// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline stall/flush sequencer (Tuse/Tnew data hazards and mult/div unit occupancy).
// Latency: stall and enables are combinational, 0 cycles; md_cnt and stall_cycles are registered.
// Backpressure: stall holds PC and F/D and injects a bubble into D/E until the hazard clears.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs_addr,
    input  logic [4:0]       D_rt_addr,
    input  logic [1:0]       D_rs_tuse,
    input  logic [1:0]       D_rt_tuse,
    input  logic             D_is_md,
    input  logic [4:0]       E_wr_addr,
    input  logic [1:0]       E_tnew,
    input  logic             E_start_mult,
    input  logic             E_start_div,
    input  logic [4:0]       M_wr_addr,
    input  logic [1:0]       M_tnew,
    output logic             stall,
    output logic             PC_WrEn,
    output logic             FD_WrEn,
    output logic             DE_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic [31:0]      stall_cycles
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t        md_state;
    md_state_t        md_state_nxt;
    logic [CNT_W-1:0] md_cnt_nxt;

    logic rs_hit_e;
    logic rs_hit_m;
    logic rt_hit_e;
    logic rt_hit_m;
    logic data_stall;
    logic md_stall;

    // $0 is hardwired, so a zero address never creates a dependency.
    assign rs_hit_e = (D_rs_addr == E_wr_addr) && (D_rs_addr != 5'd0);
    assign rs_hit_m = (D_rs_addr == M_wr_addr) && (D_rs_addr != 5'd0);
    assign rt_hit_e = (D_rt_addr == E_wr_addr) && (D_rt_addr != 5'd0);
    assign rt_hit_m = (D_rt_addr == M_wr_addr) && (D_rt_addr != 5'd0);

    assign data_stall = (rs_hit_e && (D_rs_tuse < E_tnew)) ||
                        (rs_hit_m && (D_rs_tuse < M_tnew)) ||
                        (rt_hit_e && (D_rt_tuse < E_tnew)) ||
                        (rt_hit_m && (D_rt_tuse < M_tnew));

    assign md_busy  = (md_state == MD_BUSY);
    assign md_stall = D_is_md && (md_busy || E_start_mult || E_start_div);

    assign stall    = !reset && (data_stall || md_stall);
    assign PC_WrEn  = !stall;
    assign FD_WrEn  = !stall;
    assign DE_flush = stall;

    // A start seen while busy is ignored; div takes priority over mult.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (E_start_div) begin
                    md_cnt_nxt   = CNT_W'(DIV_CYCLES);
                    md_state_nxt = MD_BUSY;
                end else if (E_start_mult) begin
                    md_cnt_nxt   = CNT_W'(MULT_CYCLES);
                    md_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_cnt_nxt = md_cnt - 1'b1;
                if (md_cnt == CNT_W'(1)) begin
                    md_state_nxt = MD_IDLE;
                end
            end
            default: begin
                md_state_nxt = MD_IDLE;
                md_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state     <= MD_IDLE;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expectations are queued by the stimulus and checked by a monitor.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wr_addr;
    logic [1:0]  E_tnew;
    logic        E_start_mult;
    logic        E_start_div;
    logic [4:0]  M_wr_addr;
    logic [1:0]  M_tnew;
    logic        stall;
    logic        PC_WrEn;
    logic        FD_WrEn;
    logic        DE_flush;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cycles;

    hazard_stall_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_tuse   (D_rs_tuse),
        .D_rt_tuse   (D_rt_tuse),
        .D_is_md     (D_is_md),
        .E_wr_addr   (E_wr_addr),
        .E_tnew      (E_tnew),
        .E_start_mult(E_start_mult),
        .E_start_div (E_start_div),
        .M_wr_addr   (M_wr_addr),
        .M_tnew      (M_tnew),
        .stall       (stall),
        .PC_WrEn     (PC_WrEn),
        .FD_WrEn     (FD_WrEn),
        .DE_flush    (DE_flush),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [3:0]  cnt;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    event sample_ev;

    task automatic expect_out(input string name, input logic s, input logic b,
                              input logic [3:0] c, input logic [31:0] sc);
        exp_t e;
        e.name  = name;
        e.stall = s;
        e.busy  = b;
        e.cnt   = c;
        e.sc    = sc;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        D_rs_addr    = 5'd0;
        D_rt_addr    = 5'd0;
        D_rs_tuse    = 2'd3;
        D_rt_tuse    = 2'd3;
        D_is_md      = 1'b0;
        E_wr_addr    = 5'd0;
        E_tnew       = 2'd0;
        E_start_mult = 1'b0;
        E_start_div  = 1'b0;
        M_wr_addr    = 5'd0;
        M_tnew       = 2'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: outputs are presented every cycle; one queued expectation per sample point.
    initial begin
        logic [40:0] act;
        logic [40:0] req;
        exp_t        e;
        forever begin
            @(negedge clk or sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {stall, PC_WrEn, FD_WrEn, DE_flush, md_busy, md_cnt, stall_cycles};
                req = {e.stall, ~e.stall, ~e.stall, e.stall, e.busy, e.cnt, e.sc};
                tests_run++;
                if (act !== req) begin
                    tests_failed++;
                    $display("FAIL %s: got stall=%b pc=%b fd=%b flush=%b busy=%b cnt=%0d sc=%0d, want stall=%b pc=%b fd=%b flush=%b busy=%b cnt=%0d sc=%0d",
                             e.name, stall, PC_WrEn, FD_WrEn, DE_flush, md_busy, md_cnt, stall_cycles,
                             req[40], req[39], req[38], req[37], req[36], req[35:32], req[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();

        // Reset high masks a live hazard.
        cyc(); reset = 1'b1;
        D_rs_addr = 5'd8; D_rs_tuse = 2'd1; E_wr_addr = 5'd8; E_tnew = 2'd2;
        expect_out("reset_masks_hazard", 1'b0, 1'b0, 4'd0, 32'd0);

        // Load-use: lw in E, then in M with a rs consumer that needs it now.
        cyc(); reset = 1'b0;
        D_rs_addr = 5'd8; D_rs_tuse = 2'd1; E_wr_addr = 5'd8; E_tnew = 2'd2;
        expect_out("load_use_E", 1'b1, 1'b0, 4'd0, 32'd0);
        cyc(); D_rs_addr = 5'd8; D_rs_tuse = 2'd0; M_wr_addr = 5'd8; M_tnew = 2'd1;
        expect_out("load_use_M", 1'b1, 1'b0, 4'd0, 32'd1);
        cyc(); D_rs_addr = 5'd8; D_rs_tuse = 2'd0; M_wr_addr = 5'd8; M_tnew = 2'd0;
        expect_out("M_tnew0", 1'b0, 1'b0, 4'd0, 32'd2);
        cyc(); D_rt_addr = 5'd8; D_rt_tuse = 2'd1; M_wr_addr = 5'd8; M_tnew = 2'd1;
        expect_out("rt_equal_tuse_tnew", 1'b0, 1'b0, 4'd0, 32'd2);
        cyc(); D_rs_addr = 5'd0; D_rs_tuse = 2'd0; E_wr_addr = 5'd0; E_tnew = 2'd2;
        expect_out("reg0_no_hazard", 1'b0, 1'b0, 4'd0, 32'd2);
        cyc(); D_rt_addr = 5'd5; D_rt_tuse = 2'd0; E_wr_addr = 5'd5; E_tnew = 2'd1;
        expect_out("rt_hit_E", 1'b1, 1'b0, 4'd0, 32'd2);
        cyc(); D_rs_addr = 5'd9; D_rs_tuse = 2'd3; E_wr_addr = 5'd9; E_tnew = 2'd2;
        expect_out("tuse3_no_stall", 1'b0, 1'b0, 4'd0, 32'd3);

        // Mult: start cycle plus five busy cycles stall an md consumer.
        cyc(); E_start_mult = 1'b1; D_is_md = 1'b1;
        expect_out("mult_start", 1'b1, 1'b0, 4'd0, 32'd3);
        for (int i = 0; i < 5; i++) begin
            cyc(); D_is_md = 1'b1;
            expect_out("mult_busy", 1'b1, 1'b1, 4'(5 - i), 32'(4 + i));
        end
        cyc(); D_is_md = 1'b1;
        expect_out("mult_done", 1'b0, 1'b0, 4'd0, 32'd9);

        // Div: non-md instructions flow while the unit is busy.
        cyc(); E_start_div = 1'b1;
        expect_out("div_start_nonmd", 1'b0, 1'b0, 4'd0, 32'd9);
        for (int i = 0; i < 3; i++) begin
            cyc(); D_rs_addr = 5'd3; D_rs_tuse = 2'd1;
            expect_out("div_busy_nonmd", 1'b0, 1'b1, 4'(10 - i), 32'd9);
        end
        cyc(); D_is_md = 1'b1;
        expect_out("div_busy_md", 1'b1, 1'b1, 4'd7, 32'd9);

        // Asynchronous reset mid-divide, between clock edges.
        @(negedge clk);
        #2;
        reset = 1'b1;
        D_is_md = 1'b1;
        expect_out("async_reset_mid_div", 1'b0, 1'b0, 4'd0, 32'd0);
        ->sample_ev;
        cyc(); reset = 1'b1; D_is_md = 1'b1; E_start_div = 1'b1;
        expect_out("reset_held", 1'b0, 1'b0, 4'd0, 32'd0);
        cyc(); reset = 1'b0;
        expect_out("after_reset", 1'b0, 1'b0, 4'd0, 32'd0);

        // Both starts (div wins) and a double rs/rt hit that counts once.
        cyc(); E_start_mult = 1'b1; E_start_div = 1'b1;
        E_wr_addr = 5'd4; E_tnew = 2'd2;
        D_rs_addr = 5'd4; D_rs_tuse = 2'd0; D_rt_addr = 5'd4; D_rt_tuse = 2'd1;
        expect_out("both_start_double_hit", 1'b1, 1'b0, 4'd0, 32'd0);
        cyc();
        expect_out("div_wins", 1'b0, 1'b1, 4'd10, 32'd1);
        cyc(); D_is_md = 1'b1;
        expect_out("md_stall_busy", 1'b1, 1'b1, 4'd9, 32'd1);
        cyc();
        expect_out("busy_idle_D", 1'b0, 1'b1, 4'd8, 32'd2);
        cyc(); E_start_mult = 1'b1;
        expect_out("start_while_busy", 1'b0, 1'b1, 4'd7, 32'd2);
        cyc();
        expect_out("start_ignored", 1'b0, 1'b1, 4'd6, 32'd2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
